// File: rtl/uart_owner_arb.sv
// uart_owner_arb: ownership arbiter for the shared UART.
// Keeps a FIFO of pending requester IDs; the head owns the UART.
// A one-cycle SETTLE gap separates consecutive owners.
// Optional inactivity watchdog: define UART_ARB_TIMEOUT_EN.
module uart_owner_arb #(
  parameter int ID_W  = 8,
  parameter int DEPTH = 4,
  parameter int TO_W  = 16,
  localparam int PW   = $clog2(DEPTH),
  localparam int CW   = PW + 1
) (
  input  logic            clk_i,
  input  logic            arst_ni,
  input  logic            push_i,
  input  logic [ID_W-1:0] push_id_i,
  output logic            push_err_o,
  input  logic            pop_i,
  input  logic [ID_W-1:0] pop_id_i,
  output logic            pop_err_o,
  output logic            gnt_valid_o,
  output logic [ID_W-1:0] gnt_id_o,
  output logic [CW-1:0]   count_o,
  input  logic            activity_i,
  input  logic [TO_W-1:0] to_limit_i,
  output logic            timeout_o
);

  typedef enum logic [1:0] {IDLE, GRANT, SETTLE} state_e;

  state_e            state_q, state_d;
  logic [ID_W-1:0]   mem_q [DEPTH];
  logic [ID_W-1:0]   mem_d [DEPTH];
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic              gnt_valid_q, gnt_valid_d;
  logic [ID_W-1:0]   gnt_id_q, gnt_id_d;
  logic              push_err_q, push_err_d;
  logic              pop_err_q, pop_err_d;
  logic              timeout_q, timeout_d;

  logic              pop_acc, push_acc, remove, dup, to_fire;

`ifdef UART_ARB_TIMEOUT_EN
  logic [TO_W-1:0]   wd_q, wd_d;

  // Watchdog: fire on the limit-th consecutive idle GRANT cycle; a legal pop wins.
  always_comb begin
    to_fire = (state_q == GRANT) && !pop_acc && (to_limit_i != '0) &&
              !activity_i && (wd_q == to_limit_i - 1'b1);
    wd_d    = '0;
    if (state_q == GRANT && state_d == GRANT && !activity_i) wd_d = wd_q + 1'b1;
  end

  // Watchdog counter register
  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) wd_q <= '0;
    else          wd_q <= wd_d;
  end
`else
  logic unused_wd;
  assign unused_wd = ^{activity_i, to_limit_i};
  assign to_fire   = 1'b0;
`endif

  // Accept rules, queue update, FSM next state and registered output values
  always_comb begin
    pop_acc = pop_i && (state_q == GRANT) && (pop_id_i == gnt_id_q);
    remove  = pop_acc || to_fire;

    // Duplicate check ignores the head when it leaves this cycle
    dup = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if ((CW'(i) < count_q) && !(remove && i == 0) &&
          (mem_q[rd_ptr_q + PW'(i)] == push_id_i))
        dup = 1'b1;
    end

    push_acc = push_i && ((count_q < CW'(DEPTH)) || remove) && !dup;

    mem_d = mem_q;
    if (push_acc) mem_d[wr_ptr_q] = push_id_i;

    rd_ptr_d = remove   ? rd_ptr_q + PW'(1) : rd_ptr_q;
    wr_ptr_d = push_acc ? wr_ptr_q + PW'(1) : wr_ptr_q;

    count_d = count_q;
    if (push_acc && !remove)      count_d = count_q + CW'(1);
    else if (!push_acc && remove) count_d = count_q - CW'(1);

    state_d = state_q;
    unique case (state_q)
      IDLE:    if (count_d != '0) state_d = GRANT;
      GRANT:   if (remove) state_d = SETTLE;
      SETTLE:  state_d = (count_d != '0) ? GRANT : IDLE;
      default: state_d = IDLE;
    endcase

    gnt_valid_d = (state_d == GRANT);
    gnt_id_d    = gnt_valid_d ? mem_d[rd_ptr_d] : '0;
    push_err_d  = push_i && !push_acc;
    pop_err_d   = pop_i && !pop_acc;
    timeout_d   = to_fire;
  end

  // State, queue and output registers
  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      state_q     <= IDLE;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      count_q     <= '0;
      gnt_valid_q <= 1'b0;
      gnt_id_q    <= '0;
      push_err_q  <= 1'b0;
      pop_err_q   <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      mem_q       <= mem_d;
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      count_q     <= count_d;
      gnt_valid_q <= gnt_valid_d;
      gnt_id_q    <= gnt_id_d;
      push_err_q  <= push_err_d;
      pop_err_q   <= pop_err_d;
      timeout_q   <= timeout_d;
    end
  end

  assign push_err_o  = push_err_q;
  assign pop_err_o   = pop_err_q;
  assign gnt_valid_o = gnt_valid_q;
  assign gnt_id_o    = gnt_id_q;
  assign count_o     = count_q;
  assign timeout_o   = timeout_q;

endmodule

// File: tb/tb_uart_owner_arb.sv
// Bench for uart_owner_arb: directed steps plus random traffic against
// a queue-based reference model. Timeout checks need UART_ARB_TIMEOUT_EN.
module tb_uart_owner_arb;
  logic       clk = 0, arst_ni = 0;
  logic       push_i = 0, pop_i = 0, activity_i = 0;
  logic [7:0] push_id_i = 0, pop_id_i = 0, gnt_id_o;
  logic       push_err_o, pop_err_o, gnt_valid_o, timeout_o;
  logic [2:0] count_o;
  logic [15:0] to_limit_i = 0;

  int total = 0, bad = 0;

  // reference model state
  logic [7:0] mq[$];
  bit  m_gnt;
  int  m_idle;

  uart_owner_arb dut (
    .clk_i(clk), .arst_ni(arst_ni),
    .push_i(push_i), .push_id_i(push_id_i), .push_err_o(push_err_o),
    .pop_i(pop_i), .pop_id_i(pop_id_i), .pop_err_o(pop_err_o),
    .gnt_valid_o(gnt_valid_o), .gnt_id_o(gnt_id_o), .count_o(count_o),
    .activity_i(activity_i), .to_limit_i(to_limit_i), .timeout_o(timeout_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_gnt  = 0;
    m_idle = 0;
  endtask

  // One clock: drive at negedge, model the rules, check at next negedge.
  task automatic step(input bit ps, input logic [7:0] pid, input bit pp,
                      input logic [7:0] poid, input bit act);
    bit pop_ok, to, rem, dup, push_ok, was_gnt;
    push_i = ps; push_id_i = pid; pop_i = pp; pop_id_i = poid; activity_i = act;
    was_gnt = m_gnt;
    pop_ok  = pp && m_gnt && (poid == mq[0]);
    to = 0;
`ifdef UART_ARB_TIMEOUT_EN
    to = m_gnt && !pop_ok && (to_limit_i != 0) && !act && (m_idle + 1 == int'(to_limit_i));
`endif
    rem = pop_ok || to;
    dup = 0;
    foreach (mq[i]) if (!(rem && i == 0) && mq[i] == pid) dup = 1;
    push_ok = ps && (mq.size() < 4 || rem) && !dup;
    if (rem) void'(mq.pop_front());
    if (push_ok) mq.push_back(pid);
    if (rem) m_gnt = 0;
    else if (!m_gnt) m_gnt = (mq.size() > 0);
    if (was_gnt && m_gnt && !act) m_idle = m_idle + 1;
    else m_idle = 0;
    @(posedge clk);
    @(negedge clk);
    chk("gnt_valid", gnt_valid_o, m_gnt);
    chk("gnt_id", gnt_id_o, m_gnt ? mq[0] : 8'h00);
    chk("count", count_o, mq.size());
    chk("push_err", push_err_o, ps && !push_ok);
    chk("pop_err", pop_err_o, pp && !pop_ok);
    chk("timeout", timeout_o, to);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 8'h00, 0, 8'h00, 0);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_gv"}, gnt_valid_o, 0);
    chk({tag, "_gid"}, gnt_id_o, 0);
    chk({tag, "_cnt"}, count_o, 0);
    chk({tag, "_errs"}, {push_err_o, pop_err_o, timeout_o}, 0);
  endtask

  initial begin
    int cnt, tos;
    model_reset();
    #12;
    chk_zero("reset");
    @(negedge clk);
    arst_ni = 1;
    @(negedge clk);
    chk_zero("post_reset");

    // single push grants next cycle
    step(1, 8'h11, 0, 8'h00, 0);
    chk("first_owner", gnt_id_o, 8'h11);
    chk("first_count", count_o, 1);

    // handoff with settle gap
    step(1, 8'h22, 0, 8'h00, 0);
    step(1, 8'h33, 0, 8'h00, 0);
    step(0, 8'h00, 1, 8'h11, 0);
    chk("settle_gap", gnt_valid_o, 0);
    idle(1);
    chk("second_owner", gnt_id_o, 8'h22);
    chk("second_count", count_o, 2);
    step(0, 8'h00, 1, 8'h22, 0); idle(1);
    step(0, 8'h00, 1, 8'h33, 0); idle(1);
    step(0, 8'h00, 1, 8'h55, 0);
    chk("pop_idle_err", pop_err_o, 1);
    idle(1);
    chk("err_one_cycle", pop_err_o, 0);

    // full queue, duplicates, bad pop, simultaneous pop+push
    for (int i = 1; i <= 4; i++) step(1, 8'(i), 0, 8'h00, 0);
    step(1, 8'h05, 0, 8'h00, 0);
    chk("full_err", push_err_o, 1);
    chk("full_count", count_o, 4);
    step(0, 8'h00, 1, 8'h99, 0);
    chk("bad_pop_owner", gnt_id_o, 8'h01);
    step(1, 8'h01, 1, 8'h01, 0);
    chk("swap_count", count_o, 4);
    chk("swap_push_err", push_err_o, 0);
    idle(1);
    chk("swap_next", gnt_id_o, 8'h02);
    step(0, 8'h00, 1, 8'h02, 0); idle(1);
    step(1, 8'h03, 0, 8'h00, 0);
    chk("dup_err", push_err_o, 1);
    chk("dup_count", count_o, 3);
    for (int g = 0; g < 8 && mq.size() > 0; g++) begin
      step(0, 8'h00, 1, mq[0], 0);
      idle(1);
    end
    chk("drained", count_o, 0);

    // watchdog
    to_limit_i = 16'd10;
    step(1, 8'h41, 0, 8'h00, 0);
    cnt = 0;
    for (int i = 0; i < 40; i++) begin
      if (timeout_o) break;
      if (gnt_valid_o) cnt++;
      step(i == 0, 8'h42, 0, 8'h00, 0);
    end
`ifdef UART_ARB_TIMEOUT_EN
    chk("to_grant_cycles", cnt, 10);
    chk("to_pulse", timeout_o, 1);
    idle(1);
    chk("to_next_owner", gnt_id_o, 8'h42);
`else
    chk("no_to_pulse", timeout_o, 0);
`endif
    tos = 0;
    for (int i = 0; i < 30; i++) begin
      step(0, 8'h00, 0, 8'h00, (i % 5) == 4);
      if (timeout_o) tos++;
    end
    chk("activity_no_to", tos, 0);
    for (int g = 0; g < 4 && mq.size() > 0; g++) begin
      step(0, 8'h00, 1, mq[0], 1);
      idle(1);
    end
    to_limit_i = 0;

    // reset mid-grant
    step(1, 8'h77, 0, 8'h00, 0);
    step(1, 8'h78, 1, 8'h77, 0);
    arst_ni = 0;
    #1;
    chk_zero("mid_reset");
    model_reset();
    @(posedge clk);
    @(negedge clk);
    chk_zero("mid_reset_hold");
    arst_ni = 1;
    step(1, 8'h79, 0, 8'h00, 0);
    chk("after_reset_count", count_o, 1);

    // random traffic
`ifdef UART_ARB_TIMEOUT_EN
    to_limit_i = 16'd6;
`endif
    for (int i = 0; i < 400; i++) begin
      logic [7:0] pid, poid;
      pid  = 8'($urandom_range(1, 6));
      poid = ($urandom_range(0, 3) != 0 && mq.size() > 0) ? mq[0] : 8'($urandom_range(1, 8));
      step($urandom_range(0, 1) == 1, pid, $urandom_range(0, 2) == 0, poid,
           $urandom_range(0, 3) == 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
